// File: rtl/ram_req_ctrl_pkg.sv
// Shared constants and state encoding for the RAM request controller.
// Optional power-on zero fill is enabled with RAM_REQ_CTRL_INIT_EN.
package ram_ctrl_pkg;

    localparam int unsigned DEF_DATA_W     = 128;
    localparam int unsigned DEF_ADDR_W     = 3;
    localparam int unsigned DEF_RD_LATENCY = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RESP    = 2'd2,
        ST_INIT    = 2'd3
    } state_t;

    // Latency counter must hold RD_LATENCY; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned lat);
        return (lat < 2) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/ram.sv
// Single-port RAM with a configurable registered read pipeline (0 = combinational read).
module ram #(
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned ADDR_W     = 3,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) r_mem[addr] <= data_in;
    end

    generate
        if (RD_LATENCY == 0) begin : g_comb
            assign data_out = r_mem[addr];
        end else begin : g_pipe
            logic [DATA_W-1:0] r_pipe [RD_LATENCY];
            always_ff @(posedge clk) begin
                r_pipe[0] <= r_mem[addr];
                for (int i = 1; i < int'(RD_LATENCY); i++) r_pipe[i] <= r_pipe[i-1];
            end
            assign data_out = r_pipe[RD_LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/ram_req_ctrl.sv
// Valid/ready command front end for the single-port RAM, one read outstanding.
// Define RAM_REQ_CTRL_INIT_EN to zero-fill the RAM after reset before accepting commands.
module ram_req_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned RD_LATENCY = DEF_RD_LATENCY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy
);

    localparam int unsigned CNT_W = cnt_width(RD_LATENCY);
    localparam int unsigned DEPTH = 1 << ADDR_W;

`ifdef RAM_REQ_CTRL_INIT_EN
    localparam state_t RST_STATE = ST_INIT;
    logic [ADDR_W-1:0] r_init_addr;
`else
    localparam state_t RST_STATE = ST_IDLE;
`endif

    state_t            r_state;
    logic              r_live;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_mem_wr_en;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data_in;
    logic              w_req_ready;

    // r_live keeps req_ready/busy low while reset is held and until the first edge.
    assign w_req_ready = r_live && (r_state == ST_IDLE);
    assign req_ready   = w_req_ready;
    assign busy        = r_live && (r_state != ST_IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign mem_wr_en   = r_mem_wr_en;
    assign mem_addr    = r_mem_addr;
    assign mem_data_in = r_mem_data_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RST_STATE;
            r_live        <= 1'b0;
            r_cnt         <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_mem_wr_en   <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_data_in <= '0;
`ifdef RAM_REQ_CTRL_INIT_EN
            r_init_addr   <= '0;
`endif
        end else begin
            r_live      <= 1'b1;
            r_mem_wr_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && w_req_ready) begin
                        r_mem_addr <= req_addr;
                        if (req_we) begin
                            r_mem_wr_en   <= 1'b1;
                            r_mem_data_in <= req_wdata;
                        end else begin
                            r_cnt   <= CNT_W'(RD_LATENCY);
                            r_state <= ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (r_cnt == '0) begin
                        r_rsp_rdata <= mem_data_out;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
`ifdef RAM_REQ_CTRL_INIT_EN
                ST_INIT: begin
                    r_mem_wr_en   <= 1'b1;
                    r_mem_addr    <= r_init_addr;
                    r_mem_data_in <= '0;
                    r_init_addr   <= r_init_addr + ADDR_W'(1);
                    if (r_init_addr == ADDR_W'(DEPTH - 1)) r_state <= ST_IDLE;
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
